paddle_control: RTL and testbench

PADDLE_CONTROL -- requirements
Module: paddle_control

---
 rtl/paddle_control.sv | 99 +++++++++
 tb/tb_paddle_control.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/paddle_control.sv
// Paddle FSM for the VGA pong game: erases the paddle column, moves it one row
// on a rate-divider tick, then redraws it.
module paddle_control #(
    parameter int         PADDLE_X      = 8,
    parameter int         PADDLE_LEN    = 16,
    parameter int         SCREEN_H      = 120,
    parameter logic [2:0] PADDLE_COLOUR = 3'b111
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       up,
    input  logic       down,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [6:0] paddle_y,
    output logic       busy
);

    localparam int             CW       = $clog2(PADDLE_LEN + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PADDLE_LEN - 1);
    localparam logic [6:0]     Y_MAX    = 7'(SCREEN_H - PADDLE_LEN);
    localparam logic [6:0]     Y_INIT   = 7'((SCREEN_H - PADDLE_LEN) / 2);

    typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          pending;
    logic          dir_up;
    logic          request;
    logic          move_ok;

    always_comb begin
        request = tick | pending;
        move_ok = (up & ~down & (paddle_y != '0)) |
                  (down & ~up & (paddle_y != Y_MAX));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= DRAW;
            cnt      <= '0;
            pending  <= 1'b0;
            dir_up   <= 1'b0;
            paddle_y <= Y_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        pending <= 1'b0;
                        if (move_ok) begin
                            dir_up <= up;
                            cnt    <= '0;
                            state  <= ERASE;
                        end
                    end
                end
                ERASE: begin
                    if (tick) pending <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= UPDATE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                UPDATE: begin
                    if (tick) pending <= 1'b1;
                    paddle_y <= dir_up ? paddle_y - 7'd1 : paddle_y + 7'd1;
                    cnt      <= '0;
                    state    <= DRAW;
                end
                DRAW: begin
                    if (tick) pending <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset state is DRAW, so plot is gated by reset_n to stay quiet while held in reset.
    always_comb begin
        plot   = reset_n & ((state == ERASE) | (state == DRAW));
        x      = 8'(PADDLE_X);
        y      = ((state == ERASE) | (state == DRAW)) ? paddle_y + 7'(cnt) : paddle_y;
        colour = (state == DRAW) ? PADDLE_COLOUR : 3'b000;
        busy   = (state != IDLE);
    end

endmodule

// File: tb/tb_paddle_control.sv
// Randomized bench for paddle_control against a transaction-level model that
// expands each accepted move into its expected per-cycle pixel stream.
module tb_paddle_control;

    localparam int LEN   = 16;
    localparam int H     = 120;
    localparam int PX    = 8;
    localparam int YMAX  = H - LEN;
    localparam int YINIT = (H - LEN) / 2;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic [6:0] paddle_y;
    logic       busy;

    paddle_control #(
        .PADDLE_X      (PX),
        .PADDLE_LEN    (LEN),
        .SCREEN_H      (H),
        .PADDLE_COLOUR (3'b111)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .tick     (tick),
        .up       (up),
        .down     (down),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .paddle_y (paddle_y),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit plot;
        int y;
        int colour;
        int py;
    } ent_t;

    ent_t q[$];
    int   m_py;
    bit   m_pend;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_moves  = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // A move is one row shift: erase old span, one quiet cycle, draw new span.
    function automatic void model_start_move(input int delta);
        int old_y = m_py;
        int new_y = m_py + delta;
        for (int i = 0; i < LEN; i++) q.push_back('{1'b1, old_y + i, 0, old_y});
        q.push_back('{1'b0, 0, 0, old_y});
        for (int i = 0; i < LEN; i++) q.push_back('{1'b1, new_y + i, 7, new_y});
        m_py = new_y;
        n_moves++;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_py   = YINIT;
        m_pend = 1'b0;
        for (int i = 0; i < LEN; i++) q.push_back('{1'b1, YINIT + i, 7, YINIT});
    endfunction

    function automatic void model_step(input bit t, input bit u, input bit d);
        if (q.size() != 0) begin
            if (t) m_pend = 1'b1;
            void'(q.pop_front());
        end else if (t || m_pend) begin
            m_pend = 1'b0;
            if (u && !d && m_py != 0) model_start_move(-1);
            else if (d && !u && m_py != YMAX) model_start_move(1);
        end
    endfunction

    task automatic cycle(input bit t, input bit u, input bit d);
        @(negedge clock);
        if (q.size() != 0) begin
            check_eq("busy", int'(busy), 1);
            check_eq("paddle_y", int'(paddle_y), q[0].py);
            check_eq("plot", int'(plot), int'(q[0].plot));
            if (q[0].plot) begin
                check_eq("x", int'(x), PX);
                check_eq("y", int'(y), q[0].y);
                check_eq("colour", int'(colour), q[0].colour);
            end
        end else begin
            check_eq("idle_busy", int'(busy), 0);
            check_eq("idle_plot", int'(plot), 0);
            check_eq("idle_paddle_y", int'(paddle_y), m_py);
            check_eq("idle_y", int'(y), m_py);
            check_eq("idle_x", int'(x), PX);
            check_eq("idle_colour", int'(colour), 0);
        end
        tick = t;
        up   = u;
        down = d;
        model_step(t, u, d);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        tick = 1'b0;
        #1;
        check_eq("rst_plot", int'(plot), 0);
        check_eq("rst_paddle_y", int'(paddle_y), YINIT);
        check_eq("rst_busy", int'(busy), 1);
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;
    endtask

    task automatic random_run(input int cycles, input int tick_max);
        for (int i = 0; i < cycles; i++)
            cycle($urandom_range(0, tick_max) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);
    endtask

    initial begin
        int moves_before;

        // Initial reset and power-on draw
        do_reset();
        repeat (20) cycle(1'b0, 1'b0, 1'b0);

        // Single upward move
        moves_before = n_moves;
        cycle(1'b1, 1'b1, 1'b0);
        repeat (40) cycle(1'b0, 1'b1, 1'b0);
        check_eq("up_moves", n_moves - moves_before, 1);
        check_eq("up_final_y", int'(paddle_y), YINIT - 1);

        // Down with extra ticks mid-move: one pending, one dropped
        do_reset();
        repeat (20) cycle(1'b0, 1'b0, 1'b0);
        moves_before = n_moves;
        for (int c = 0; c < 80; c++)
            cycle(c == 0 || c == 5 || c == 10, 1'b0, 1'b1);
        check_eq("bb_moves", n_moves - moves_before, 2);
        check_eq("bb_final_y", int'(paddle_y), YINIT + 2);

        // Both pressed: tick consumed, nothing moves
        repeat (3) cycle(1'b1, 1'b1, 1'b1);
        repeat (40) cycle(1'b0, 1'b0, 1'b1);
        check_eq("both_final_y", int'(paddle_y), YINIT + 2);

        // Drive to the top boundary and hammer it
        repeat (2100) cycle(1'b1, 1'b1, 1'b0);
        check_eq("top_y", int'(paddle_y), 0);

        // Drive to the bottom boundary and hammer it
        repeat (3800) cycle(1'b1, 1'b0, 1'b1);
        check_eq("bottom_y", int'(paddle_y), YMAX);

        random_run(3000, 7);

        // Reset mid-move
        while (q.size() != 0) cycle(1'b0, 1'b0, 1'b0);
        if (m_py != 0) cycle(1'b1, 1'b1, 1'b0);
        else cycle(1'b1, 1'b0, 1'b1);
        repeat (20) cycle($urandom_range(0, 1) == 1, 1'b0, 1'b0);
        do_reset();
        random_run(1500, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
